// File: rtl/serial_word_receiver_pkg.sv
// Shared Hack word-path constants for the serial word receiver.
package serial_word_receiver_pkg;

  // Native Hack data word width.
  localparam int HACK_WORD_W = 16;

  // Width of the consumed-word counter; it wraps at 2**HACK_CNT_W.
  localparam int HACK_CNT_W  = 16;

endpackage

// File: rtl/serial_word_receiver_bit_shifter.sv
// Bit assembler: shift register plus bit counter.
// word_next is the register value with bit_in shifted in. When the incoming
// bit completes a word, the parent captures word_next and the shifter clears.
module bit_shifter #(
  parameter int WIDTH     = 16,
  parameter int LSB_FIRST = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  // Select where new bits enter the word, based on the bit ordering.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign word_next = {bit_in, sr[WIDTH-1:1]};
    end else begin : g_msb
      assign word_next = {sr[WIDTH-2:0], bit_in};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));

  // Shift on accept; wrap to an empty register once the word is handed off.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      if (last) begin
        sr  <= '0;
        cnt <= '0;
      end else begin
        sr  <= word_next;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Bit-serial to word deserializer for the Hack memory-mapped I/O word path.
// Accepts one bit per in handshake. Presents each completed word through a
// single holding register with a valid/ready handshake.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH     = HACK_WORD_W,
  parameter int LSB_FIRST = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_bit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HACK_CNT_W-1:0] word_count
);

  logic             acc;
  logic             take;
  logic             complete;
  logic             last;
  logic [WIDTH-1:0] word_next;

  // The final bit of a word may enter only if the holding register is free or
  // is being emptied in this cycle. That makes out_ready -> in_ready the only
  // combinational path through the block.
  assign in_ready = !reset && !flush && (!last || !out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign complete = acc && last;

  bit_shifter #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clock    (clock),
    .reset    (reset),
    .shift_en (acc),
    .clr      (flush),
    .bit_in   (in_bit),
    .word_next(word_next),
    .last     (last)
  );

  // Holding register: a completed word is loaded even when the previous word
  // is taken in the same cycle, so back-to-back words have no bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (complete) begin
      out_word  <= word_next;
      out_valid <= 1'b1;
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

  // Count consumed words; the counter wraps naturally at its width.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_count <= '0;
    end else if (take) begin
      word_count <= word_count + HACK_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver. Two instances share the same
// inputs: one is MSB-first and the other is LSB-first, so each bit stream
// checks both orderings.
module tb_serial_word_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        rdy0, rdy1, vld0, vld1;
  logic [15:0] word0, word1, cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int exp_wc = 0;

  always #5 clock = ~clock;

  serial_word_receiver #(.WIDTH(16), .LSB_FIRST(0)) dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(rdy0), .out_word(word0), .out_valid(vld0), .out_ready(out_ready),
    .word_count(cnt0));

  serial_word_receiver #(.WIDTH(16), .LSB_FIRST(1)) dut1 (
    .clock(clock), .reset(reset), .flush(flush), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(rdy1), .out_word(word1), .out_valid(vld1), .out_ready(out_ready),
    .word_count(cnt1));

  typedef struct {
    logic [15:0] seq;   // bit stream; seq[15] is sent first
    logic [15:0] exp0;  // expected MSB-first word
    logic [15:0] exp1;  // expected LSB-first word
  } vec_t;

  vec_t tbl[5];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one bit and wait, within a bounded number of cycles, until it is accepted.
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    in_bit   = b;
    in_valid = 1'b1;
    #1;
    while (!rdy0 && n < 50) begin
      step();
      n++;
    end
    if (!rdy0) chk("accept_timeout", 32'(rdy0), 32'd1);
    step();
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] w4[3];
    logic [15:0] beef;
    int          nvld;
    int          stall;

    tbl[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5};
    tbl[1] = '{16'h8000, 16'h8000, 16'h0001};  // 16'h0001 sent LSB-first
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[3] = '{16'h1234, 16'h1234, 16'h2C48};
    tbl[4] = '{16'hBEEF, 16'hBEEF, 16'hF77D};
    w4[0] = 16'h0F0F;
    w4[1] = 16'hF00F;
    w4[2] = 16'h5A5A;
    beef  = 16'hBEEF;

    // Reset: in_ready is low while reset is high, and all state clears.
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("in_ready_in_reset", 32'(rdy0), 32'd0);
    step();
    step();
    chk("reset_out_valid", 32'(vld0), 32'd0);
    chk("reset_out_word", 32'(word0), 32'd0);
    chk("reset_word_count", 32'(cnt0), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;

    // 16'hA5C3 MSB-first with out_ready held high.
    out_ready = 1'b1;
    send_word(16'hA5C3);
    chk("t1_out_valid", 32'(vld0), 32'd1);
    chk("t1_out_word", 32'(word0), 32'hA5C3);
    chk("t1_out_word_lsb", 32'(word1), 32'hC3A5);
    chk("t1_count_before_take", 32'(cnt0), 32'd0);
    step();
    exp_wc = 1;
    chk("t1_word_count", 32'(cnt0), 32'(exp_wc));
    chk("t1_valid_cleared", 32'(vld0), 32'd0);
    out_ready = 1'b0;

    // Table: assemble each word with no consumer, then take it once.
    for (int k = 0; k < 5; k++) begin
      send_word(tbl[k].seq);
      chk($sformatf("tbl%0d_valid", k), 32'(vld0 & vld1), 32'd1);
      chk($sformatf("tbl%0d_word_msb", k), 32'(word0), 32'(tbl[k].exp0));
      chk($sformatf("tbl%0d_word_lsb", k), 32'(word1), 32'(tbl[k].exp1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_wc++;
      chk($sformatf("tbl%0d_count", k), 32'(cnt0), 32'(exp_wc));
      chk($sformatf("tbl%0d_valid_off", k), 32'(vld0), 32'd0);
      chk($sformatf("tbl%0d_word_hold", k), 32'(word0), 32'(tbl[k].exp0));
    end

    // Backpressure: the first word is held and the final bit stalls.
    send_word(16'h1234);
    chk("bp_first_word", 32'(word0), 32'h1234);
    for (int i = 15; i >= 1; i--) send_bit(beef[i]);
    in_bit   = beef[0];
    in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", 32'(rdy0), 32'd0);
    step();
    step();
    chk("bp_word_held", 32'(word0), 32'h1234);
    chk("bp_still_stalled", 32'(rdy0), 32'd0);
    chk("bp_valid_held", 32'(vld0), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 32'(rdy0), 32'd1);
    step();
    exp_wc++;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_second_word", 32'(word0), 32'hBEEF);
    chk("bp_second_word_lsb", 32'(word1), 32'hF77D);
    chk("bp_valid_no_bubble", 32'(vld0), 32'd1);
    chk("bp_count", 32'(cnt0), 32'(exp_wc));
    step();
    chk("bp_second_stable", 32'(word0), 32'hBEEF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Continuous streaming for 48 cycles after a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    nvld  = 0;
    stall = 0;
    for (int i = 0; i < 48; i++) begin
      in_bit   = w4[i / 16][15 - (i % 16)];
      in_valid = 1'b1;
      #1;
      if (!rdy0) stall++;
      step();
      if (vld0) begin
        if (nvld < 3) chk($sformatf("stream_word%0d", nvld), 32'(word0), 32'(w4[nvld]));
        nvld++;
      end
    end
    in_valid = 1'b0;
    chk("stream_no_stall", 32'(stall), 32'd0);
    chk("stream_words_seen", 32'(nvld), 32'd3);
    chk("stream_count_pre", 32'(cnt0), 32'd2);
    step();
    chk("stream_count", 32'(cnt0), 32'd3);
    chk("stream_valid_off", 32'(vld0), 32'd0);
    out_ready = 1'b0;

    // Flush drops a partial word, and the bit offered during the flush is ignored.
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    flush    = 1'b1;
    in_bit   = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 32'(rdy0), 32'd0);
    step();
    flush = 1'b0;
    for (int i = 0; i < 15; i++) send_bit(1'b1);
    in_valid = 1'b0;
    #1;
    chk("flush_not_early", 32'(vld0), 32'd0);
    send_bit(1'b1);
    in_valid = 1'b0;
    chk("flush_valid", 32'(vld0), 32'd1);
    chk("flush_word", 32'(word0), 32'hFFFF);
    chk("flush_count_kept", 32'(cnt0), 32'd3);

    // Reset with a partial word pending and out_valid high.
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("rst6_in_ready", 32'(rdy0), 32'd0);
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst6_valid", 32'(vld0), 32'd0);
    chk("rst6_count", 32'(cnt0), 32'd0);
    chk("rst6_word", 32'(word0), 32'd0);
    send_word(16'hA5C3);
    chk("rst6_next_valid", 32'(vld0), 32'd1);
    chk("rst6_next_word", 32'(word0), 32'hA5C3);
    chk("rst6_next_word_lsb", 32'(word1), 32'hC3A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
